seseg_rx: RTL and testbench

- Reader for a multiplexed, active-low 4-digit seven-segment display bus (segment lines plus anode selects).
- Samples the bus and waits until each digit's pattern is stable.
- Decodes stable patterns back to hex nibbles and keeps a 4-digit shadow register with per-digit valid flags and error reporting.
- Sits on the display output path as a loopback checker and as a scraper for boards that only expose a seven-segment bus.

---
 rtl/seseg_rx.sv | 184 ++++++++++++++++++
 tb/tb_seseg_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seseg_rx.sv
// rtl/seseg_rx.sv - seven-segment bus reader with stability filter and hex decode
//
// Watches a multiplexed, active-low 4-digit seven-segment bus, waits until a
// digit's pattern has been stable for STABLE_CYCLES samples, and decodes it
// back into a 4-digit hex shadow register.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   seg[6:0]   segment lines, active-low, bit0=a .. bit6=g
//   an[3:0]    digit anodes, active-low, one low bit selects a digit
//   digits     decoded nibbles, digits[4i+3:4i] is digit i
//   dig_valid  digit i currently holds a decoded hex value
//   upd        one-cycle pulse, a digit was captured as hex or blank
//   upd_digit  index of the captured digit, holds its last value
//   err        one-cycle pulse, a stable pattern was not a legal glyph
//   err_digit  index of the offending digit, holds its last value

module seseg_rx #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  dig_valid,
  output logic        upd,
  output logic [1:0]  upd_digit,
  output logic        err,
  output logic [1:0]  err_digit
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  // Count value at which the next matching sample completes the run.
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;

  // Registered bus sample and the pattern of the run being tracked.
  logic [6:0] s_seg;
  logic [3:0] s_an;
  logic [6:0] r_seg;
  logic [3:0] r_an;

  logic       legal;
  logic [1:0] sel;
  logic       same;
  logic [3:0] nib;
  logic       is_hex;
  logic       is_blank;

  // Exactly one low anode bit selects a digit; idle and conflicts are not legal.
  always_comb begin
    legal = 1'b1;
    sel   = 2'd0;
    case (s_an)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  assign same = (s_seg == r_seg) && (s_an == r_an);

  // Glyph decode, written g..a to match the segment ordering.
  always_comb begin
    nib      = 4'h0;
    is_hex   = 1'b1;
    is_blank = 1'b0;
    case (s_seg)
      7'b1000000: nib = 4'h0;
      7'b1111001: nib = 4'h1;
      7'b0100100: nib = 4'h2;
      7'b0110000: nib = 4'h3;
      7'b0011001: nib = 4'h4;
      7'b0010010: nib = 4'h5;
      7'b0000010: nib = 4'h6;
      7'b1011000: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0010000: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b0000011: nib = 4'hB;
      7'b1000110: nib = 4'hC;
      7'b0100001: nib = 4'hD;
      7'b0000110: nib = 4'hE;
      7'b0001110: nib = 4'hF;
      7'b1111111: begin
        is_hex   = 1'b0;
        is_blank = 1'b1;
      end
      default: is_hex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg     <= 7'h7F;
      s_an      <= 4'hF;
      r_seg     <= 7'h7F;
      r_an      <= 4'hF;
      state     <= IDLE;
      count     <= '0;
      digits    <= '0;
      dig_valid <= '0;
      upd       <= 1'b0;
      upd_digit <= 2'd0;
      err       <= 1'b0;
      err_digit <= 2'd0;
    end else begin
      s_seg <= seg;
      s_an  <= an;
      upd   <= 1'b0;
      err   <= 1'b0;

      if (!legal) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= TRACK;
            count <= ONE;
            r_seg <= s_seg;
            r_an  <= s_an;
          end

          TRACK: begin
            if (!same) begin
              count <= ONE;
              r_seg <= s_seg;
              r_an  <= s_an;
            end else if (count == LAST) begin
              // Run complete: capture once, then sit in HELD until it changes.
              count <= count + ONE;
              state <= HELD;
              if (is_hex) begin
                digits[4*sel +: 4] <= nib;
                dig_valid[sel]     <= 1'b1;
                upd                <= 1'b1;
                upd_digit          <= sel;
              end else if (is_blank) begin
                dig_valid[sel] <= 1'b0;
                upd            <= 1'b1;
                upd_digit      <= sel;
              end else begin
                dig_valid[sel] <= 1'b0;
                err            <= 1'b1;
                err_digit      <= sel;
              end
            end else begin
              count <= count + ONE;
            end
          end

          HELD: begin
            if (!same) begin
              state <= TRACK;
              count <= ONE;
              r_seg <= s_seg;
              r_an  <= s_an;
            end
          end

          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seseg_rx.sv
// tb/tb_seseg_rx.sv - randomized self-checking bench for seseg_rx

module tb_seseg_rx;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an  = 4'hF;
  logic [15:0] digits;
  logic [3:0]  dig_valid;
  logic        upd;
  logic [1:0]  upd_digit;
  logic        err;
  logic [1:0]  err_digit;

  int passed = 0;
  int total  = 0;

  seseg_rx #(.STABLE_CYCLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .an        (an),
    .digits    (digits),
    .dig_valid (dig_valid),
    .upd       (upd),
    .upd_digit (upd_digit),
    .err       (err),
    .err_digit (err_digit)
  );

  always #5 clk = ~clk;

  // Glyph for each hex value, g..a, active-low.
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: run-length view of the input stream.
  logic [15:0] m_digits;
  logic [3:0]  m_valid;
  logic        m_upd, m_err;
  logic [1:0]  m_ud, m_ed;
  logic        pend;
  logic [6:0]  p_seg, last_seg;
  logic [3:0]  p_an, last_an;
  logic        have_last;
  int          run;

  function automatic int zero_count(input logic [3:0] a);
    int c = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) c++;
    return c;
  endfunction

  function automatic logic [1:0] zero_idx(input logic [3:0] a);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (!a[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [25:0] obs_vec();
    return {upd, upd_digit, err, err_digit, digits, dig_valid};
  endfunction

  function automatic logic [25:0] exp_vec();
    return {m_upd, m_ud, m_err, m_ed, m_digits, m_valid};
  endfunction

  task automatic apply_capture();
    int idx;
    int found;
    idx = int'(zero_idx(p_an));
    found = -1;
    for (int k = 0; k < 16; k++) if (glyph[k] == p_seg) found = k;
    if (found >= 0) begin
      m_digits[4*idx +: 4] = 4'(found);
      m_valid[idx] = 1'b1;
      m_upd = 1'b1;
      m_ud  = 2'(idx);
    end else if (p_seg == 7'h7F) begin
      m_valid[idx] = 1'b0;
      m_upd = 1'b1;
      m_ud  = 2'(idx);
    end else begin
      m_valid[idx] = 1'b0;
      m_err = 1'b1;
      m_ed  = 2'(idx);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic tick(input logic [6:0] sv, input logic [3:0] av, input logic r);
    seg = sv;
    an  = av;
    rst = r;
    @(posedge clk);
    m_upd = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_digits = '0; m_valid = '0; m_ud = '0; m_ed = '0;
      pend = 1'b0; have_last = 1'b0; run = 0;
    end else begin
      if (pend) apply_capture();
      pend = 1'b0;
      if (have_last && sv == last_seg && av == last_an) begin
        if (run < 1000) run++;
      end else begin
        run = 1; last_seg = sv; last_an = av; have_last = 1'b1;
      end
      if (run == N && zero_count(av) == 1) begin
        pend = 1'b1; p_seg = sv; p_an = av;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(7'h7F, 4'hF, 1'b1);
      total++;
      if (obs_vec() !== 26'h0) $display("FAIL reset: got %h want %h", obs_vec(), 26'h0);
      else passed++;
    end
    tick(7'h7F, 4'hF, 1'b0);
  endtask

  task automatic test_basic();
    int n_upd = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) tick(7'b0110000, 4'b1011, 1'b0);
      else       tick(7'h7F, 4'hF, 1'b0);
      n_upd += int'(upd);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL basic c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (n_upd != 1 || upd_digit !== 2'd2 || digits !== 16'h0300 || dig_valid !== 4'b0100)
      $display("FAIL basic_final: got upd#%0d ud=%0d d=%h v=%b want upd#1 ud=2 d=0300 v=0100",
               n_upd, upd_digit, digits, dig_valid);
    else passed++;
  endtask

  task automatic test_short();
    int n_ev = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) tick(7'b0000110, 4'b1110, 1'b0);
      else       tick(7'b0000110, 4'b1111, 1'b0);
      n_ev += int'(upd) + int'(err);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL short c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (n_ev != 0 || digits !== 16'h0300 || dig_valid !== 4'b0100)
      $display("FAIL short_final: got ev=%0d d=%h v=%b want ev=0 d=0300 v=0100", n_ev, digits, dig_valid);
    else passed++;
  endtask

  task automatic test_err_blank();
    int n_err = 0;
    int n_upd = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) tick(7'b1111110, 4'b1101, 1'b0);
      else       tick(7'h7F, 4'hF, 1'b0);
      n_err += int'(err);
      n_upd += int'(upd);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL err c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (n_err != 1 || n_upd != 0 || err_digit !== 2'd1 || dig_valid[1] !== 1'b0 || digits !== 16'h0300)
      $display("FAIL err_final: got err#%0d upd#%0d ed=%0d d=%h want err#1 upd#0 ed=1 d=0300",
               n_err, n_upd, err_digit, digits);
    else passed++;
    n_upd = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) tick(7'b1111111, 4'b1101, 1'b0);
      else       tick(7'h7F, 4'hF, 1'b0);
      n_upd += int'(upd);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL blank c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (n_upd != 1 || upd_digit !== 2'd1 || dig_valid !== 4'b0100)
      $display("FAIL blank_final: got upd#%0d ud=%0d v=%b want upd#1 ud=1 v=0100", n_upd, upd_digit, dig_valid);
    else passed++;
  endtask

  task automatic test_conflict();
    int n_ev = 0;
    for (int i = 0; i < 10; i++) begin
      tick(glyph[5], 4'b1001, 1'b0);
      n_ev += int'(upd) + int'(err);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL conflict c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (n_ev != 0) $display("FAIL conflict_none: got %0d events want 0", n_ev);
    else passed++;
    n_ev = 0;
    for (int i = 0; i < 21; i++) begin
      if (i < 20) tick(glyph[5], 4'b0111, 1'b0);
      else        tick(7'h7F, 4'hF, 1'b0);
      n_ev += int'(upd);
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL long c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (n_ev != 1 || upd_digit !== 2'd3 || digits[15:12] !== 4'h5 || dig_valid[3] !== 1'b1)
      $display("FAIL long_final: got upd#%0d ud=%0d d3=%h want upd#1 ud=3 d3=5", n_ev, upd_digit, digits[15:12]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n_upd = 0;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick(glyph[k], ~(4'b0001 << (k % 4)), 1'b0);
        n_upd += int'(upd);
        total++;
        if (obs_vec() !== exp_vec()) $display("FAIL sweep k%0d c%0d: got %h want %h", k, c, obs_vec(), exp_vec());
        else passed++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(7'h7F, 4'hF, 1'b0);
      n_upd += int'(upd);
    end
    total++;
    if (n_upd != 16 || digits !== 16'hFEDC || dig_valid !== 4'hF)
      $display("FAIL sweep_final: got upd#%0d d=%h v=%h want upd#16 d=FEDC v=F", n_upd, digits, dig_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    tick(glyph[9], 4'b1110, 1'b0);
    tick(glyph[9], 4'b1110, 1'b0);
    tick(glyph[9], 4'b1110, 1'b1);
    total++;
    if (obs_vec() !== 26'h0) $display("FAIL rstmid_clear: got %h want %h", obs_vec(), 26'h0);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      tick(glyph[9], 4'b1110, 1'b0);
      total++;
      if (upd !== (i == 4)) $display("FAIL rstmid c%0d: got upd=%b want %b", i, upd, (i == 4));
      else passed++;
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL rstmid_model c%0d: got %h want %h", i, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (digits !== 16'h0009 || dig_valid !== 4'b0001)
      $display("FAIL rstmid_final: got d=%h v=%b want d=0009 v=0001", digits, dig_valid);
    else passed++;
  endtask

  task automatic test_random();
    logic [6:0] sv;
    logic [3:0] av;
    logic       r;
    int         len;
    for (int blk = 0; blk < 150; blk++) begin
      case ($urandom_range(0, 19))
        0, 1, 2:  sv = 7'h7F;
        3, 4, 5:  sv = 7'($urandom);
        default:  sv = glyph[$urandom_range(0, 15)];
      endcase
      case ($urandom_range(0, 9))
        0:       av = 4'hF;
        1:       av = 4'($urandom);
        default: av = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++) begin
        r = ($urandom_range(0, 99) == 0);
        tick(sv, av, r);
        total++;
        if (obs_vec() !== exp_vec()) $display("FAIL random b%0d c%0d: got %h want %h", blk, c, obs_vec(), exp_vec());
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_err_blank();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
